alu_serial: RTL and testbench

- Parametrised, registered successor to the combinational 8-bit CPU ALU.
- Operand width is WIDTH bits.
- ADC/SBC run digit-serially: one 4-bit digit per clock, least significant first, with per-digit BCD correction in decimal mode. This covers both add and subtract.
- Logic and rotate ops complete in one clock.
- Sits between the datapath operand registers and the status/result registers, under a start/busy/done handshake from the sequencer.

---
 rtl/alu_serial_if.sv | 28 ++
 rtl/alu_serial.sv | 159 +++++++++++++++
 tb/tb_alu_serial.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_if.sv
// Sequencer <-> serial ALU bus: operand/request side and result/status side.
interface alu_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic             dec;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic             ci;
    logic [WIDTH-1:0] out;
    logic             c;
    logic             n;
    logic             z;
    logic             v;
    logic             busy;
    logic             done;

    modport master (
        output start, op, dec, ai, bi, ci,
        input  out, c, n, z, v, busy, done
    );

    modport slave (
        input  start, op, dec, ai, bi, ci,
        output out, c, n, z, v, busy, done
    );
endinterface

// File: rtl/alu_serial.sv
// Registered ALU: ADC/SBC processed one 4-bit digit per clock (LSD first,
// optional BCD correction); logic and rotate ops finish in one clock.
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | digits 1..NDIG-1 of ADC/SBC being processed, busy=1
// FIN    | result/flags valid, done=1; a new start is accepted here too
module alu_serial #(
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         reset_n,
    alu_serial_if.slave bus
);
    localparam int NDIG = WIDTH / 4;
    localparam int KW   = $clog2(NDIG);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SBC = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;
    localparam logic [2:0] OP_ORA = 3'd5;
    localparam logic [2:0] OP_EOR = 3'd6;
    localparam logic [2:0] OP_AND = 3'd7;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_r, b_r, acc_r, out_r;
    logic             dec_r, sub_r, carry_r, c_r, v_r;

    logic             sub_live, arith_live;
    logic [4:0]       dig0;
    logic [5:0]       dk;
    logic [WIDTH-1:0] acc_next, res;
    logic             cf;

    // One digit: returns {overflow, carry_out, digit}. Overflow is taken from
    // the uncorrected binary sum so it means the same thing in both modes.
    function automatic logic [5:0] digit_calc(input logic [3:0] a, input logic [3:0] b,
                                              input logic cin, input logic dm, input logic sub);
        logic [4:0] s;
        logic [3:0] d;
        logic       co;
        s  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        d  = s[3:0];
        co = s[4];
        if (dm && !sub) begin
            if (s > 5'd9) begin
                d  = s[3:0] + 4'd6;
                co = 1'b1;
            end else begin
                co = 1'b0;
            end
        end else if (dm && sub && !s[4]) begin
            d = s[3:0] + 4'd10;
        end
        return {s[3] ^ a[3] ^ b[3] ^ s[4], co, d};
    endfunction

    // Digit 0 comes straight from the live inputs at the accepting edge.
    always_comb begin
        sub_live   = (bus.op == OP_SBC);
        arith_live = (bus.op == OP_ADC) || sub_live;
        dig0       = 5'(digit_calc(bus.ai[3:0], bus.bi[3:0] ^ {4{sub_live}},
                                   bus.ci, bus.dec, sub_live));
    end

    // Later digits come from the latched operands, selected by k.
    always_comb begin
        dk       = digit_calc(a_r[{k, 2'b00} +: 4], b_r[{k, 2'b00} +: 4] ^ {4{sub_r}},
                              carry_r, dec_r, sub_r);
        acc_next = acc_r;
        acc_next[{k, 2'b00} +: 4] = dk[3:0];
    end

    // Single-cycle ops; carry passes through unless the op is a rotate.
    always_comb begin
        res = bus.ai;
        cf  = bus.ci;
        case (bus.op)
            OP_ROL: begin
                res = {bus.ai[WIDTH-2:0], bus.ci};
                cf  = bus.ai[WIDTH-1];
            end
            OP_ROR: begin
                res = {bus.ci, bus.ai[WIDTH-1:1]};
                cf  = bus.ai[0];
            end
            OP_ORA:  res = bus.ai | bus.bi;
            OP_EOR:  res = bus.ai ^ bus.bi;
            OP_AND:  res = bus.ai & bus.bi;
            default: ;
        endcase
    end

    // Sequencer, digit pipeline and result/flag registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            k       <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            out_r   <= '0;
            dec_r   <= 1'b0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            c_r     <= 1'b0;
            v_r     <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    carry_r <= dk[4];
                    acc_r   <= acc_next;
                    k       <= k + 1'b1;
                    if (k == KW'(NDIG - 1)) begin
                        out_r <= acc_next;
                        c_r   <= dk[4];
                        v_r   <= dk[5];
                        state <= S_FIN;
                    end
                end
                default: begin
                    if (bus.start) begin
                        a_r   <= bus.ai;
                        b_r   <= bus.bi;
                        dec_r <= bus.dec;
                        sub_r <= sub_live;
                        if (arith_live) begin
                            state   <= S_RUN;
                            k       <= KW'(1);
                            carry_r <= dig0[4];
                            acc_r   <= {{(WIDTH-4){1'b0}}, dig0[3:0]};
                        end else begin
                            state <= S_FIN;
                            out_r <= res;
                            c_r   <= cf;
                            v_r   <= 1'b0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.out  = out_r;
    assign bus.c    = c_r;
    assign bus.v    = v_r;
    assign bus.n    = out_r[WIDTH-1];
    assign bus.z    = (out_r == '0);
    assign bus.busy = (state == S_RUN);
    assign bus.done = (state == S_FIN);
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial at WIDTH=8 and WIDTH=16 against an integer-arithmetic model.
module tb_alu_serial;
    logic clk = 1'b0;
    logic rst8_n, rst16_n;
    int   checks = 0;
    int   failures = 0;

    alu_serial_if #(.WIDTH(8))  if8 ();
    alu_serial_if #(.WIDTH(16)) if16 ();

    alu_serial #(.WIDTH(8))  u8  (.clk(clk), .reset_n(rst8_n),  .bus(if8.slave));
    alu_serial #(.WIDTH(16)) u16 (.clk(clk), .reset_n(rst16_n), .bus(if16.slave));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint bcd2int(input logic [15:0] x, input int nd);
        longint r = 0;
        for (int d = nd - 1; d >= 0; d--) r = r * 10 + longint'(x[4*d +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input longint t, input int nd);
        logic [15:0] r = '0;
        longint      u = t;
        for (int d = 0; d < nd; d++) begin
            r[4*d +: 4] = 4'(u % 10);
            u = u / 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd(input int w);
        logic [15:0] r = '0;
        for (int d = 0; d < w / 4; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // Reference: whole-word binary arithmetic, or decimal integer arithmetic on BCD values.
    function automatic void model(input int w, input logic [2:0] op, input logic dm,
                                  input logic [15:0] a, input logic [15:0] b, input logic ci,
                                  output logic [15:0] r, output logic c, output logic v);
        longint      mask = (longint'(1) << w) - 1;
        longint      s, ta, tb, p, pl, t;
        logic [15:0] bm;
        logic [4:0]  at, bt, st;
        logic        cin_top;
        v = 1'b0;
        c = ci;
        r = a;
        case (op)
            3'd1, 3'd2: begin
                bm = (op == 3'd2) ? 16'(~b & 16'(mask)) : b;
                if (!dm) begin
                    s = longint'(a) + longint'(bm) + longint'(ci);
                    r = 16'(s & mask);
                    c = s[w];
                    v = (a[w-1] == bm[w-1]) && (r[w-1] != a[w-1]);
                end else begin
                    p = 1;
                    for (int i = 0; i < w / 4; i++) p = p * 10;
                    pl = p / 10;
                    ta = bcd2int(a, w / 4);
                    tb = bcd2int(b, w / 4);
                    if (op == 3'd1) begin
                        t       = ta + tb + longint'(ci);
                        c       = (t >= p);
                        cin_top = ((ta % pl) + (tb % pl) + longint'(ci)) >= pl;
                        t       = t % p;
                    end else begin
                        t       = ta - tb - longint'(!ci);
                        c       = (t >= 0);
                        cin_top = ((ta % pl) - (tb % pl) - longint'(!ci)) >= 0;
                        if (t < 0) t = t + p;
                    end
                    r  = int2bcd(t, w / 4);
                    at = {1'b0, 4'(a >> (w - 4))};
                    bt = {1'b0, 4'(bm >> (w - 4))};
                    st = at + bt + {4'b0, cin_top};
                    v  = (at[3] == bt[3]) && (st[3] != at[3]);
                end
            end
            3'd3: begin r = 16'(((longint'(a) << 1) | longint'(ci)) & mask); c = a[w-1]; end
            3'd4: begin r = 16'((longint'(a) >> 1) | (longint'(ci) << (w - 1))); c = a[0]; end
            3'd5: r = a | b;
            3'd6: r = a ^ b;
            3'd7: r = a & b;
            default: ;
        endcase
    endfunction

    task automatic drive(input int w, input logic st, input logic [2:0] op, input logic dm,
                         input logic [15:0] a, input logic [15:0] b, input logic ci);
        if (w == 8) begin
            if8.start = st; if8.op = op; if8.dec = dm; if8.ai = a[7:0]; if8.bi = b[7:0]; if8.ci = ci;
        end else begin
            if16.start = st; if16.op = op; if16.dec = dm; if16.ai = a; if16.bi = b; if16.ci = ci;
        end
    endtask

    task automatic sample(input int w, output logic [15:0] o, output logic c, output logic n,
                          output logic z, output logic v, output logic bz, output logic dn);
        if (w == 8) begin
            o = {8'h00, if8.out}; c = if8.c; n = if8.n; z = if8.z; v = if8.v; bz = if8.busy; dn = if8.done;
        end else begin
            o = if16.out; c = if16.c; n = if16.n; z = if16.z; v = if16.v; bz = if16.busy; dn = if16.done;
        end
    endtask

    // Called at a negedge; returns at the negedge where done is high.
    task automatic run_op(input int w, input logic [2:0] op, input logic dm,
                          input logic [15:0] a, input logic [15:0] b, input logic ci, input string tag,
                          output logic [15:0] ro, output logic co, output logic vo,
                          output logic no, output logic zo, output int lat);
        logic [15:0] er;
        logic        ec, ev, bo, dn, got;
        int          bcnt, el;
        model(w, op, dm, a, b, ci, er, ec, ev);
        el = (op == 3'd1 || op == 3'd2) ? w / 4 : 1;
        drive(w, 1'b1, op, dm, a, b, ci);
        @(posedge clk);
        @(negedge clk);
        drive(w, 1'b0, 3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
        got = 1'b0; bcnt = 0; lat = 0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            if (cyc > 1) @(negedge clk);
            sample(w, ro, co, no, zo, vo, bo, dn);
            if (dn) begin got = 1'b1; lat = cyc; end
            else if (bo) bcnt++;
        end
        chk({tag, "_done_seen"}, got, 1'b1);
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_busy_cycles"}, bcnt, el - 1);
        chk({tag, "_out"}, ro, er);
        chk({tag, "_c"}, co, ec);
        chk({tag, "_v"}, vo, ev);
        chk({tag, "_n"}, no, er[w-1]);
        chk({tag, "_z"}, zo, er == 16'h0);
    endtask

    task automatic pulse_end(input int w, input string tag);
        logic [15:0] o;
        logic        c, n, z, v, bz, dn;
        @(negedge clk);
        sample(w, o, c, n, z, v, bz, dn);
        chk({tag, "_done_pulse"}, dn, 1'b0);
    endtask

    initial begin
        logic [15:0] ro, a, b;
        logic        co, vo, no, zo, bz, dn, dm, ci;
        logic [2:0]  op;
        int          lat, dones;

        rst8_n = 1'b0; rst16_n = 1'b0;
        drive(8, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0);
        drive(16, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        sample(8, ro, co, no, zo, vo, bz, dn);
        chk("rst8_out", ro, 16'h0); chk("rst8_c", co, 1'b0); chk("rst8_n", no, 1'b0);
        chk("rst8_z", zo, 1'b1); chk("rst8_v", vo, 1'b0); chk("rst8_busy", bz, 1'b0); chk("rst8_done", dn, 1'b0);
        sample(16, ro, co, no, zo, vo, bz, dn);
        chk("rst16_z", zo, 1'b1); chk("rst16_busy", bz, 1'b0); chk("rst16_done", dn, 1'b0);
        rst8_n = 1'b1; rst16_n = 1'b1;
        @(negedge clk);

        run_op(8, 3'd1, 1'b0, 16'h50, 16'h50, 1'b0, "adc_bin", ro, co, vo, no, zo, lat);
        chk("adc_bin_const_out", ro, 16'hA0); chk("adc_bin_const_v", vo, 1'b1);
        chk("adc_bin_const_c", co, 1'b0); chk("adc_bin_const_lat", lat, 2);
        pulse_end(8, "adc_bin");
        run_op(8, 3'd1, 1'b1, 16'h58, 16'h46, 1'b1, "adc_dec", ro, co, vo, no, zo, lat);
        chk("adc_dec_const_out", ro, 16'h05); chk("adc_dec_const_c", co, 1'b1);
        pulse_end(8, "adc_dec");
        run_op(8, 3'd2, 1'b1, 16'h12, 16'h21, 1'b1, "sbc_dec", ro, co, vo, no, zo, lat);
        chk("sbc_dec_const_out", ro, 16'h91); chk("sbc_dec_const_c", co, 1'b0); chk("sbc_dec_const_n", no, 1'b1);
        pulse_end(8, "sbc_dec");
        run_op(8, 3'd4, 1'b0, 16'h01, 16'h00, 1'b1, "ror", ro, co, vo, no, zo, lat);
        chk("ror_const_out", ro, 16'h80); chk("ror_const_c", co, 1'b1); chk("ror_const_lat", lat, 1);
        pulse_end(8, "ror");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom); dm = 1'($urandom); ci = 1'($urandom);
            a = (dm && (op == 3'd1 || op == 3'd2)) ? rand_bcd(8) : 16'($urandom_range(0, 255));
            b = (dm && (op == 3'd1 || op == 3'd2)) ? rand_bcd(8) : 16'($urandom_range(0, 255));
            run_op(8, op, dm, a, b, ci, $sformatf("r8_%0d_op%0d", i, op), ro, co, vo, no, zo, lat);
            if ($urandom_range(0, 2) != 0) pulse_end(8, "r8");
        end
        pulse_end(8, "r8_last");

        // WIDTH=16 decimal carry through all digits; a start during busy must be ignored.
        drive(16, 1'b1, 3'd1, 1'b1, 16'h9999, 16'h0001, 1'b0);
        @(posedge clk);
        dones = 0; lat = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            if (cyc == 1) drive(16, 1'b1, 3'd0, 1'b0, 16'hFFFF, 16'h0, 1'b1);
            else drive(16, 1'b0, 3'd0, 1'b0, 16'hFFFF, 16'h0, 1'b1);
            sample(16, ro, co, no, zo, vo, bz, dn);
            if (dn) begin dones++; if (lat == 0) lat = cyc; end
        end
        chk("busy_ign_dones", dones, 1); chk("busy_ign_lat", lat, 4);
        chk("busy_ign_out", ro, 16'h0000); chk("busy_ign_c", co, 1'b1); chk("busy_ign_z", zo, 1'b1);

        // Abort by reset mid-operation.
        run_op(16, 3'd0, 1'b0, 16'h1234, 16'h0, 1'b0, "ai16", ro, co, vo, no, zo, lat);
        pulse_end(16, "ai16");
        drive(16, 1'b1, 3'd1, 1'b0, 16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(16, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0, 1'b0);
        rst16_n = 1'b0;
        @(negedge clk);
        sample(16, ro, co, no, zo, vo, bz, dn);
        chk("abort_out", ro, 16'h0); chk("abort_z", zo, 1'b1);
        chk("abort_busy", bz, 1'b0); chk("abort_done", dn, 1'b0);
        rst16_n = 1'b1;
        dones = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            sample(16, ro, co, no, zo, vo, bz, dn);
            if (dn) dones++;
        end
        chk("abort_no_done", dones, 0);

        // Back-to-back: second start issued in the FIN cycle of the first.
        run_op(16, 3'd1, 1'b0, 16'h7FFF, 16'h0001, 1'b0, "b2b_a", ro, co, vo, no, zo, lat);
        run_op(16, 3'd6, 1'b0, 16'hF0F0, 16'h0FF0, 1'b1, "b2b_b", ro, co, vo, no, zo, lat);
        chk("b2b_b_const_out", ro, 16'hFF00);
        pulse_end(16, "b2b_b");

        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom); dm = 1'($urandom); ci = 1'($urandom);
            a = (dm && (op == 3'd1 || op == 3'd2)) ? rand_bcd(16) : 16'($urandom);
            b = (dm && (op == 3'd1 || op == 3'd2)) ? rand_bcd(16) : 16'($urandom);
            run_op(16, op, dm, a, b, ci, $sformatf("r16_%0d_op%0d", i, op), ro, co, vo, no, zo, lat);
            if ($urandom_range(0, 2) != 0) pulse_end(16, "r16");
        end
        pulse_end(16, "r16_last");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
